riscv_prefetch_fetch: RTL and testbench
=======================================

# riscv_prefetch_fetch

Parametrised instruction fetch unit with a DEPTH-entry prefetch buffer, replacing the single-word fetch stage between the instruction memory port and the decoder in `riscv_core`. It keeps one request in flight on the instruction memory port and queues returned words with their PCs. It hands instructions to the decoder over a valid/ready handshake, and on a redirect it flushes the buffer and cancels stale data.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: instruction address width.
- `WORD_WIDTH`, default 32: instruction word width.
- `DEPTH`, default 4: prefetch buffer entries; must be a power of two, ≥2.
- `BOOT_ADDR`, default 32'h0000_0000: first fetch address after reset; word aligned.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `target_valid_i`  in  1  redirect request; single-cycle pulse.
- `target_addr_i`  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- `instr_o`  out  WORD_WIDTH  head-of-buffer instruction.
- `pc_o`  out  ADDR_WIDTH  PC of `instr_o`.
- `instr_valid_o`  out  1  buffer non-empty.
- `instr_ready_i`  in  1  decoder accepts the head entry.
- `imem_valid_o`  out  1  fetch request.
- `imem_ready_i`  in  1  request complete; `imem_rdata_i` is valid in this cycle.
- `imem_addr_o`  out  ADDR_WIDTH  fetch address.
- `imem_wdata_o`  out  WORD_WIDTH  tied to 0.
- `imem_we_o`  out  4  tied to 0.
- `imem_rdata_i`  in  WORD_WIDTH  fetched word.

## Operation
- **Memory protocol**
  - At most one outstanding request.
  - While a request is outstanding, `imem_valid_o` and `imem_addr_o` stay high and stable until a cycle with `imem_ready_i` = 1.
  - A request is never withdrawn, including on redirect.
- **Issue rule**
  - A new request is issued when `occupancy_next + in_flight < DEPTH`.
  - The fetch address then advances by 4.
- **Buffer**
  - Each entry holds {word, pc}.
  - Push happens on a ready cycle unless that data is marked discard.
  - Pop happens when `instr_valid_o & instr_ready_i`.
  - Push and pop in the same cycle leave occupancy unchanged, including when full (the issue rule prevents push-when-full-without-pop).
- **Redirect (`target_valid_i` = 1)**
  - Buffer is flushed next cycle; flush beats a same-cycle pop and a same-cycle push.
  - The fetch PC is set to the target.
  - If a request is in flight and not completing this cycle, a discard flag is set. The request completes at its old address and its data is dropped. The first target request follows in the cycle after that ready.
  - If no request is in flight, or it completes in the redirect cycle, the target request appears on the next cycle.
  - A second redirect while discard is pending updates the target only; exactly one completion is dropped.
- **Wrap-around**
  - Fetch PC wraps modulo 2^ADDR_WIDTH.
  - FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values: `imem_valid_o` = 0, `imem_addr_o` = BOOT_ADDR, `instr_valid_o` = 0, `instr_o` = 0, `pc_o` = 0, occupancy = 0, discard = 0.
- First request: `imem_valid_o` = 1 at BOOT_ADDR in the first cycle after `rst` deasserts.
- Response latency: `imem_ready_i` in cycle N gives `instr_valid_o` = 1 in cycle N+1. There is no bypass.
- Back-to-back: when the issue rule holds at the ready cycle N, the next request is valid in N+1. With zero-wait memory this gives a peak of one word per cycle.
- Redirect latency: with an idle port, a redirect in cycle N puts the target address on `imem_addr_o` in N+1.
- Reset mid-request: all state clears and the outstanding request is abandoned. The memory model must tolerate this; the bench resets memory together with the core.

## Structure
- Shared constants stay in `riscv_defines.sv`: `RISCV_ADDR_WIDTH`, `RISCV_WORD_WIDTH`, and new `PREFETCH_DEPTH`. Parameter defaults come from these.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated once with WIDTH = WORD_WIDTH + ADDR_WIDTH.
- Top level holds the fetch PC register, in-flight and discard flags, and the issue logic.

## Test plan
- **Reset/boot:** BOOT_ADDR = 0x100, zero-wait memory, `instr_ready_i` = 1 → addresses 0x100, 0x104, 0x108 on consecutive cycles; `pc_o` follows one cycle behind each ready.
- **Backpressure:** `instr_ready_i` = 0, DEPTH = 4 → exactly 4 requests complete, then `imem_valid_o` = 0. Asserting ready for one cycle pops 0x100, and exactly one new request (0x110) issues.
- **Wait states:** memory stalls 3 cycles per request → `imem_addr_o` is stable across each stall, and `instr_o` matches the memory contents in order.
- **Redirect with request in flight:** redirect to 0x2002 during a stalled request at 0x108 → the 0x108 data is never output, the buffer is empty next cycle, and the next `pc_o` is 0x2000.
- **Simultaneous redirect, pop and ready:** all three in one cycle → the buffer is empty next cycle, the ready data is dropped, and the next request is at the target.
- **Wrap:** BOOT_ADDR = 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/riscv_prefetch_fetch_pkg.sv
// Shared constants for the prefetching instruction fetch unit.
// Parameter defaults of riscv_prefetch_fetch are taken from here so the core
// and the fetch unit agree on address/word widths and buffer depth.
package riscv_prefetch_fetch_pkg;

    localparam int unsigned RISCV_ADDR_WIDTH = 32;
    localparam int unsigned RISCV_WORD_WIDTH = 32;
    localparam int unsigned PREFETCH_DEPTH   = 4;

    // The fetch unit never writes instruction memory.
    localparam logic [3:0]  IMEM_WE_NONE     = 4'b0000;

    // Byte distance between consecutive instruction words.
    localparam int unsigned FETCH_STRIDE     = 4;

endpackage

// File: rtl/riscv_prefetch_fetch_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i/data_i write one entry (ignored when full unless popping too)
//   pop_i/data_o  remove the head entry (ignored when empty); data_o is the head
//   flush_i       discard all entries; wins over push and pop in the same cycle
//   full_o, empty_o, count_o  occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok_s = push_i & (~full_o | pop_i);
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/riscv_prefetch_fetch.sv
// riscv_prefetch_fetch: instruction fetch unit with a DEPTH-entry prefetch buffer.
// Keeps at most one request outstanding on the instruction memory port, queues
// returned words with their PCs and presents the head to the decoder.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   target_valid_i, target_addr_i    redirect pulse and target (low 2 bits ignored)
//   instr_o, pc_o, instr_valid_o     head of buffer towards the decoder
//   instr_ready_i                    decoder consumes the head entry
//   imem_valid_o, imem_addr_o        fetch request (held until imem_ready_i)
//   imem_ready_i, imem_rdata_i       request completion and returned word
//   imem_wdata_o, imem_we_o          unused write side, tied to zero
module riscv_prefetch_fetch
    import riscv_prefetch_fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = RISCV_ADDR_WIDTH,
    parameter int unsigned            WORD_WIDTH = RISCV_WORD_WIDTH,
    parameter int unsigned            DEPTH      = PREFETCH_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]  BOOT_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   target_valid_i,
    input  logic [ADDR_WIDTH-1:0]  target_addr_i,
    output logic [WORD_WIDTH-1:0]  instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic                   imem_valid_o,
    input  logic                   imem_ready_i,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [WORD_WIDTH-1:0]  imem_wdata_o,
    output logic [3:0]             imem_we_o,
    input  logic [WORD_WIDTH-1:0]  imem_rdata_i
);

    localparam int unsigned  FIFO_W  = WORD_WIDTH + ADDR_WIDTH;
    localparam int unsigned  CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;   // next address to request
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;   // address of outstanding request
    logic                  in_flight_q, in_flight_d;
    logic                  discard_q, discard_d;     // drop the next completion

    logic                  completing_s;
    logic                  issue_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic [ADDR_WIDTH-1:0] issue_addr_s;
    logic [CW-1:0]         occ_next_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;
    logic [FIFO_W-1:0]     fifo_head_s;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .flush_i (target_valid_i),
        .data_i  ({imem_rdata_i, req_addr_q}),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign instr_o       = fifo_head_s[FIFO_W-1:ADDR_WIDTH];
    assign pc_o          = fifo_head_s[ADDR_WIDTH-1:0];
    assign instr_valid_o = ~fifo_empty_s;
    assign imem_valid_o  = in_flight_q;
    assign imem_addr_o   = req_addr_q;
    assign imem_wdata_o  = {WORD_WIDTH{1'b0}};
    assign imem_we_o     = IMEM_WE_NONE;

    // Issue decision, buffer push/pop and next fetch state.
    always_comb begin
        target_s     = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
        completing_s = in_flight_q & imem_ready_i;
        fifo_pop_s   = ~fifo_empty_s & instr_ready_i;
        // A redirect flushes the buffer, so same-cycle data is dropped as well.
        fifo_push_s  = completing_s & ~discard_q & ~target_valid_i
                       & (~fifo_full_s | fifo_pop_s);

        if (target_valid_i) begin
            occ_next_s   = {CW{1'b0}};
            issue_addr_s = target_s;
        end else begin
            occ_next_s   = fifo_count_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
            issue_addr_s = fetch_pc_q;
        end

        // The port must be free after this cycle; counting the pending request
        // in the occupancy bound reduces to this since at most one is in flight.
        issue_s = (~in_flight_q | imem_ready_i) & (occ_next_s < DEPTH_C);

        if (issue_s) begin
            in_flight_d = 1'b1;
            req_addr_d  = issue_addr_s;
            fetch_pc_d  = issue_addr_s + ADDR_WIDTH'(FETCH_STRIDE);
        end else begin
            in_flight_d = in_flight_q & ~imem_ready_i;
            req_addr_d  = req_addr_q;
            fetch_pc_d  = issue_addr_s;
        end

        // Exactly one stale completion is dropped, however many redirects arrive.
        if (completing_s) begin
            discard_d = 1'b0;
        end else if (target_valid_i & in_flight_q) begin
            discard_d = 1'b1;
        end else begin
            discard_d = discard_q;
        end
    end

    // Fetch PC, request and discard state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= BOOT_ADDR;
            req_addr_q  <= BOOT_ADDR;
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

endmodule

// File: tb/tb_riscv_prefetch_fetch.sv
// Directed testbench for riscv_prefetch_fetch (BOOT_ADDR = 0x100, DEPTH = 4).
module tb_riscv_prefetch_fetch;

    logic        clk;
    logic        rst;
    logic        target_valid;
    logic [31:0] target_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [3:0]  imem_we;
    logic [31:0] imem_rdata;

    int          wait_cfg;   // stall cycles before each ready
    int          wait_cnt;
    logic        mem_hold;   // force memory stall
    int          n_done;     // completed memory requests since reset
    int          n_total;
    int          n_pass;

    riscv_prefetch_fetch #(
        .ADDR_WIDTH (32),
        .WORD_WIDTH (32),
        .DEPTH      (4),
        .BOOT_ADDR  (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .target_valid_i (target_valid),
        .target_addr_i  (target_addr),
        .instr_o        (instr),
        .pc_o           (pc),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .imem_valid_o   (imem_valid),
        .imem_ready_i   (imem_ready),
        .imem_addr_o    (imem_addr),
        .imem_wdata_o   (imem_wdata),
        .imem_we_o      (imem_we),
        .imem_rdata_i   (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ready = imem_valid && (wait_cnt >= wait_cfg) && !mem_hold;

    // Memory wait-state counter and completion counter (reset with the core).
    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
            n_done   <= 0;
        end else if (imem_valid && imem_ready) begin
            wait_cnt <= 0;
            n_done   <= n_done + 1;
        end else if (imem_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset core and memory; returns one cycle after the first non-reset edge.
    task automatic do_reset();
        rst          = 1'b1;
        target_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        wait_cfg     = 0;
        mem_hold     = 1'b0;
        instr_ready  = 1'b0;
        target_valid = 1'b0;
        target_addr  = 32'h0;
        rst          = 1'b1;

        // ---- reset values ----
        step();
        step();
        check_eq("rst_imem_valid", imem_valid, 1'b0);
        check_eq("rst_imem_addr", imem_addr, 32'h100);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("wdata_zero", imem_wdata, 32'h0);
        check_eq("we_zero", imem_we, 4'h0);

        // ---- boot, zero-wait, decoder always ready ----
        rst = 1'b0;
        step();
        check_eq("boot_valid", imem_valid, 1'b1);
        check_eq("boot_addr0", imem_addr, 32'h100);
        instr_ready = 1'b1;
        step();
        check_eq("boot_addr1", imem_addr, 32'h104);
        check_eq("boot_iv1", instr_valid, 1'b1);
        check_eq("boot_pc1", pc, 32'h100);
        check_eq("boot_instr1", instr, mem_word(32'h100));
        step();
        check_eq("boot_addr2", imem_addr, 32'h108);
        check_eq("boot_pc2", pc, 32'h104);
        check_eq("boot_instr2", instr, mem_word(32'h104));

        // ---- backpressure: buffer fills to 4, then one pop frees one slot ----
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        check_eq("bp_done4", n_done, 4);
        check_eq("bp_idle", imem_valid, 1'b0);
        check_eq("bp_pc_head", pc, 32'h100);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_eq("bp_refill_valid", imem_valid, 1'b1);
        check_eq("bp_refill_addr", imem_addr, 32'h110);
        check_eq("bp_pc_next", pc, 32'h104);
        step();
        step();
        check_eq("bp_done5", n_done, 5);
        check_eq("bp_idle2", imem_valid, 1'b0);

        // ---- wait states: 3 stall cycles per request ----
        wait_cfg    = 3;
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                check_eq("ws_addr", imem_addr, 32'h100 + 32'(4 * k));
                check_eq("ws_ready", imem_ready, (c == 3) ? 1'b1 : 1'b0);
                if (c < 3) step();
            end
            step();
            check_eq("ws_pc", pc, 32'h100 + 32'(4 * k));
            check_eq("ws_instr", instr, mem_word(32'h100 + 32'(4 * k)));
        end
        wait_cfg = 0;

        // ---- redirect while a request is stalled at 0x108 ----
        do_reset();
        step();
        step();
        check_eq("rd_addr108", imem_addr, 32'h108);
        check_eq("rd_buf_nonempty", instr_valid, 1'b1);
        mem_hold     = 1'b1;
        instr_ready  = 1'b0;
        target_valid = 1'b1;
        target_addr  = 32'h2002;
        step();
        target_valid = 1'b0;
        instr_ready  = 1'b1;
        check_eq("rd_flushed", instr_valid, 1'b0);
        check_eq("rd_hold_valid", imem_valid, 1'b1);
        check_eq("rd_hold_addr", imem_addr, 32'h108);
        step();
        check_eq("rd_hold_addr2", imem_addr, 32'h108);
        mem_hold = 1'b0;
        step();
        check_eq("rd_dropped", instr_valid, 1'b0);
        check_eq("rd_target_addr", imem_addr, 32'h2000);
        step();
        check_eq("rd_iv", instr_valid, 1'b1);
        check_eq("rd_pc", pc, 32'h2000);
        check_eq("rd_instr", instr, mem_word(32'h2000));

        // ---- redirect, pop and memory ready in the same cycle ----
        do_reset();
        step();
        check_eq("sim_pre_iv", instr_valid, 1'b1);
        check_eq("sim_pre_ready", imem_ready, 1'b1);
        target_valid = 1'b1;
        target_addr  = 32'h0000_0400;
        step();
        target_valid = 1'b0;
        check_eq("sim_empty", instr_valid, 1'b0);
        check_eq("sim_addr", imem_addr, 32'h400);
        check_eq("sim_valid", imem_valid, 1'b1);
        step();
        check_eq("sim_pc", pc, 32'h400);
        check_eq("sim_instr", instr, mem_word(32'h400));

        // ---- fetch PC wrap-around ----
        do_reset();
        target_valid = 1'b1;
        target_addr  = 32'hFFFF_FFF9;
        step();
        target_valid = 1'b0;
        check_eq("wr_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        check_eq("wr_addr1", imem_addr, 32'hFFFF_FFFC);
        check_eq("wr_pc0", pc, 32'hFFFF_FFF8);
        step();
        check_eq("wr_addr2", imem_addr, 32'h0000_0000);
        check_eq("wr_pc1", pc, 32'hFFFF_FFFC);
        step();
        check_eq("wr_pc2", pc, 32'h0000_0000);
        check_eq("wr_instr2", instr, mem_word(32'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
